// File: rtl/narnet_pkg.sv
// Shared fixed-point constants and the N-bit reduction used by the NAR-net datapath.
// Build option: define SATURATE_EN to clamp results instead of wrapping them.
package narnet_pkg;

  localparam int NARNET_N = 10;
  localparam int NARNET_Q = 8;
  localparam int FX_MAX   = 2**(NARNET_N-1) - 1;
  localparam int FX_MIN   = -(2**(NARNET_N-1));

  // Reduce a wide signed intermediate back to the datapath word.
  function automatic logic signed [NARNET_N-1:0] fx(input logic signed [2*NARNET_N-1:0] v);
`ifdef SATURATE_EN
    if (v > FX_MAX) return FX_MAX[NARNET_N-1:0];
    if (v < FX_MIN) return FX_MIN[NARNET_N-1:0];
    return v[NARNET_N-1:0];
`else
    return v[NARNET_N-1:0];
`endif
  endfunction

endpackage

// File: rtl/narnet_tanh_rom.sv
// Registered tanh lookup: a 2^N-entry table indexed by the raw argument code.
// Entries are rounded half away from zero and clamped to [-1.0, +1.0].
module narnet_tanh_rom #(
  parameter int N = 10,
  parameter int Q = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        code,
  output logic signed [N-1:0] tanh_out
);

  function automatic logic signed [N-1:0] tanh_code(input int idx);
    real v;
    real r;
    int  e;
    v = $itor((idx >= 2**(N-1)) ? idx - 2**N : idx) / (2.0 ** Q);
    r = $tanh(v) * (2.0 ** Q);
    e = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    if (e > 2**Q)            e = 2**Q;
    if (e < -(2**Q))         e = -(2**Q);
    if (e > 2**(N-1) - 1)    e = 2**(N-1) - 1;
    if (e < -(2**(N-1)))     e = -(2**(N-1));
    return e[N-1:0];
  endfunction

  logic signed [N-1:0] rom [2**N];

  for (genvar i = 0; i < 2**N; i++) begin : g_rom
    assign rom[i] = tanh_code(i);
  end

  always_ff @(posedge clk) begin
    if (rst) tanh_out <= '0;
    else     tanh_out <= rom[code];
  end

endmodule

// File: rtl/narnet_compute_unit.sv
// NAR-net arithmetic datapath: MAC neuron with bias, running-sum accumulator, tanh lookup.
// Overflow handling follows the SATURATE_EN build option (clamp when defined, wrap otherwise).
module narnet_compute_unit
  import narnet_pkg::*;
#(
  parameter int N = NARNET_N,
  parameter int Q = NARNET_Q
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mac_clr,
  input  logic                mac_valid,
  input  logic signed [N-1:0] w,
  input  logic signed [N-1:0] x,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] mac_out,
  input  logic                acc_clr,
  input  logic                acc_add,
  input  logic signed [N-1:0] acc_in,
  output logic signed [N-1:0] acc_out,
  input  logic signed [N-1:0] tanh_in,
  output logic signed [N-1:0] tanh_out
);

  logic signed [N-1:0]   m;
  logic signed [N-1:0]   prod;
  logic signed [2*N-1:0] prod_full;
  logic signed [2*N-1:0] mac_sum;
  logic signed [2*N-1:0] bias_sum;
  logic signed [2*N-1:0] acc_sum;

  // Full-precision product, rescaled by Q with floor rounding before reduction.
  assign prod_full = (2*N)'(w) * (2*N)'(x);
  assign prod      = fx(prod_full >>> Q);
  assign mac_sum   = (2*N)'(m) + (2*N)'(prod);
  assign bias_sum  = (2*N)'(m) + (2*N)'(b);
  assign acc_sum   = (2*N)'(acc_out) + (2*N)'(acc_in);

  // Bias stays outside the register so it is applied once and may change after a clear.
  assign mac_out = fx(bias_sum);

  always_ff @(posedge clk) begin
    if (rst || mac_clr) m <= '0;
    else if (mac_valid) m <= fx(mac_sum);
  end

  always_ff @(posedge clk) begin
    if (rst || acc_clr) acc_out <= '0;
    else if (acc_add)   acc_out <= fx(acc_sum);
  end

  narnet_tanh_rom #(.N(N), .Q(Q)) u_tanh_rom (
    .clk      (clk),
    .rst      (rst),
    .code     (tanh_in),
    .tanh_out (tanh_out)
  );

endmodule

// File: tb/tb_narnet_compute_unit.sv
// Self-checking bench for narnet_compute_unit: directed test-plan cases plus randomized
// traffic against an arithmetic reference model (honours SATURATE_EN like the design).
module tb_narnet_compute_unit;

  logic clk = 1'b0;
  logic rst, mac_clr, mac_valid, acc_clr, acc_add;
  logic signed [9:0] w, x, b, acc_in, tanh_in;
  logic signed [9:0] mac_out, acc_out, tanh_out;

  int n_cmp = 0;
  int n_bad = 0;
  int m_ref = 0;
  int acc_ref = 0;
  int tanh_q = 0;

  always #5 clk = ~clk;

  narnet_compute_unit dut (
    .clk       (clk),
    .rst       (rst),
    .mac_clr   (mac_clr),
    .mac_valid (mac_valid),
    .w         (w),
    .x         (x),
    .b         (b),
    .mac_out   (mac_out),
    .acc_clr   (acc_clr),
    .acc_add   (acc_add),
    .acc_in    (acc_in),
    .acc_out   (acc_out),
    .tanh_in   (tanh_in),
    .tanh_out  (tanh_out)
  );

  // Reference: reduce an integer value to the 10-bit word.
  function automatic int fx_ref(input int v);
`ifdef SATURATE_EN
    if (v > 511)  return 511;
    if (v < -512) return -512;
    return v;
`else
    return ((v % 1024) + 1024 + 512) % 1024 - 512;
`endif
  endfunction

  // Reference: product scaled by 1/256 with floor division.
  function automatic int prod_ref(input int a, input int c);
    int p;
    p = a * c;
    if (p >= 0) return fx_ref(p / 256);
    return fx_ref(-((-p + 255) / 256));
  endfunction

  // Reference: tanh of code/256, rounded half away from zero, clamped to +-256.
  function automatic int tanh_ref(input int c);
    real t;
    int  e;
    t = $tanh($itor(c) / 256.0) * 256.0;
    if (t >= 0.0) e = int'($floor(t + 0.5));
    else          e = -int'($floor(-t + 0.5));
    if (e > 256)  e = 256;
    if (e < -256) e = -256;
    return e;
  endfunction

  // Advance one clock edge, updating the reference model from the applied inputs.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_ref = 0;
      acc_ref = 0;
      tanh_q = 0;
    end else begin
      if (mac_clr)        m_ref = 0;
      else if (mac_valid) m_ref = fx_ref(m_ref + prod_ref(int'(w), int'(x)));
      if (acc_clr)        acc_ref = 0;
      else if (acc_add)   acc_ref = fx_ref(acc_ref + int'(acc_in));
      tanh_q = tanh_ref(int'(tanh_in));
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; mac_clr = 1'b0; mac_valid = 1'b0; acc_clr = 1'b0; acc_add = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mac_clr = 1'($urandom); mac_valid = 1'($urandom);
      acc_clr = 1'($urandom); acc_add = 1'($urandom);
      w = 10'($urandom); x = 10'($urandom); b = 10'($urandom);
      acc_in = 10'($urandom); tanh_in = 10'($urandom);
      tick();
    end
    n_cmp++;
    if (mac_out !== b) begin
      n_bad++; $display("[TB] FAIL reset_mac_out: got %0d expected %0d", mac_out, b);
    end
    n_cmp++;
    if (acc_out !== 10'sd0) begin
      n_bad++; $display("[TB] FAIL reset_acc_out: got %0d expected 0", acc_out);
    end
    n_cmp++;
    if (tanh_out !== 10'sd0) begin
      n_bad++; $display("[TB] FAIL reset_tanh_out: got %0d expected 0", tanh_out);
    end
    idle();
  endtask

  task automatic test_mac();
    int exp_sat;
    int exp_tab [3] = '{192, 320, 256};
    mac_clr = 1'b1; tick(); mac_clr = 1'b0;
    b = 10'sd64; w = 10'sd128; x = 10'sd256;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) mac_valid = 1'b1;
      else       b = 10'sd0;
      tick();
      mac_valid = 1'b0;
      n_cmp++;
      if (mac_out !== 10'(exp_tab[i])) begin
        n_bad++; $display("[TB] FAIL mac_step%0d: got %0d expected %0d", i, mac_out, exp_tab[i]);
      end
    end
    mac_clr = 1'b1; tick(); mac_clr = 1'b0;
    w = 10'sd511; x = 10'sd511; b = 10'sd0; mac_valid = 1'b1;
    tick();
    mac_valid = 1'b0;
`ifdef SATURATE_EN
    exp_sat = 511;
`else
    exp_sat = -4;
`endif
    n_cmp++;
    if (mac_out !== 10'(exp_sat)) begin
      n_bad++; $display("[TB] FAIL mac_overflow: got %0d expected %0d", mac_out, exp_sat);
    end
  endtask

  task automatic test_acc();
    int add_tab [3] = '{100, 200, 300};
    int exp_tab [4];
`ifdef SATURATE_EN
    exp_tab = '{100, 300, 511, 511};
`else
    exp_tab = '{100, 300, -424, -424};
`endif
    acc_clr = 1'b1; tick(); acc_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      acc_add = (i < 3);
      acc_in  = (i < 3) ? 10'(add_tab[i]) : 10'sd0;
      tick();
      n_cmp++;
      if (acc_out !== 10'(exp_tab[i])) begin
        n_bad++; $display("[TB] FAIL acc_step%0d: got %0d expected %0d", i, acc_out, exp_tab[i]);
      end
    end
    acc_add = 1'b0;
  endtask

  task automatic test_tanh();
    int in_tab  [5] = '{0, 256, -256, 511, -512};
    int exp_tab [5] = '{0, 195, -195, 247, -247};
    for (int i = 0; i < 5; i++) begin
      tanh_in = 10'(in_tab[i]);
      tick();
      n_cmp++;
      if (tanh_out !== 10'(exp_tab[i])) begin
        n_bad++; $display("[TB] FAIL tanh_%0d: got %0d expected %0d", in_tab[i], tanh_out, exp_tab[i]);
      end
    end
  endtask

  task automatic test_priority();
    mac_clr = 1'b1; tick(); mac_clr = 1'b0;
    w = 10'sd100; x = 10'sd200; b = -10'sd37; mac_valid = 1'b1;
    tick();
    mac_clr = 1'b1;
    tick();
    mac_clr = 1'b0; mac_valid = 1'b0;
    n_cmp++;
    if (mac_out !== b) begin
      n_bad++; $display("[TB] FAIL clr_over_valid: got %0d expected %0d", mac_out, b);
    end
    mac_valid = 1'b1; acc_add = 1'b1; acc_in = 10'sd77; tanh_in = 10'sd300;
    tick(); tick();
    rst = 1'b1;
    tick();
    idle();
    n_cmp++;
    if (mac_out !== b || acc_out !== 10'sd0 || tanh_out !== 10'sd0) begin
      n_bad++;
      $display("[TB] FAIL mid_reset: got mac=%0d acc=%0d tanh=%0d expected mac=%0d acc=0 tanh=0",
               mac_out, acc_out, tanh_out, b);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      mac_clr   = ($urandom_range(0, 15) == 0);
      mac_valid = 1'($urandom);
      acc_clr   = ($urandom_range(0, 15) == 0);
      acc_add   = 1'($urandom);
      w = 10'($urandom); x = 10'($urandom); b = 10'($urandom);
      acc_in = 10'($urandom); tanh_in = 10'($urandom);
      tick();
      n_cmp++;
      if (mac_out !== 10'(fx_ref(m_ref + int'(b)))) begin
        n_bad++; $display("[TB] FAIL rand_mac cyc%0d: got %0d expected %0d", i, mac_out, fx_ref(m_ref + int'(b)));
      end
      n_cmp++;
      if (acc_out !== 10'(acc_ref)) begin
        n_bad++; $display("[TB] FAIL rand_acc cyc%0d: got %0d expected %0d", i, acc_out, acc_ref);
      end
      n_cmp++;
      if (tanh_out !== 10'(tanh_q)) begin
        n_bad++; $display("[TB] FAIL rand_tanh cyc%0d: got %0d expected %0d", i, tanh_out, tanh_q);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    w = '0; x = '0; b = '0; acc_in = '0; tanh_in = '0;
    @(negedge clk);
    test_reset();
    test_mac();
    test_acc();
    test_tanh();
    test_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
